serial_sub8: RTL and testbench
==============================

SERIAL_SUB8 -- requirements
Module: serial_sub8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1: request to capture operands and begin one subtraction.
REQ-005 The block SHALL have port a, input, WIDTH: minuend, sampled only on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH: subtrahend, sampled only on the accepting edge.
REQ-007 The block SHALL have port bin, input, 1: borrow-in, sampled only on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1: high while the block is in state RUN.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse marking that a new result is valid.
REQ-010 The block SHALL have port diff, output, WIDTH: result a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1: borrow-out of the MSB stage (1 = unsigned a < b + bin).
REQ-012 The block SHALL have port ovf, output, 1: signed two's-complement overflow of the subtraction.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN and DONE, all transitions on the rising edge of clk.
REQ-014 In IDLE, start=1 SHALL be accepted on that edge (edge E0):
- a, b and bin are copied into internal shift and borrow registers.
- The bit counter is cleared to 0.
- The state moves to RUN.
REQ-015 On each edge in RUN, the block SHALL process one bit, LSB first:
- d = a0 ^ b0 ^ br.
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
- d is shifted into the MSB of the internal result register.
- The operand registers shift right by one.
- The counter increments by one.
REQ-016 RUN SHALL last exactly WIDTH edges (E1..E_WIDTH); on E_WIDTH the state moves to DONE.
REQ-017 On E_WIDTH, diff, bout and ovf SHALL be loaded together from the completed internal result.
- ovf = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]), using the captured operands.
REQ-018 diff, bout and ovf SHALL NOT show partial results; they hold their previous values from E0 until E_WIDTH.
REQ-019 diff, bout and ovf SHALL hold until the next E_WIDTH or reset.
REQ-020 done SHALL be 1 exactly in the cycle between E_WIDTH and E_WIDTH+1 (state DONE), and 0 otherwise.
REQ-021 From DONE the FSM SHALL always return to IDLE on the next edge.
REQ-022 start SHALL be ignored in RUN and DONE.
- Operands applied during RUN or DONE have no effect on the operation in progress.
REQ-023 With start held at 1 continuously, operations SHALL repeat back-to-back:
- one accepted start every WIDTH+2 cycles;
- done pulses WIDTH+2 cycles apart.
REQ-024 busy SHALL be 1 from E0 until E_WIDTH, and 0 in IDLE and DONE.
REQ-025 Start-to-done latency SHALL be fixed at WIDTH edges after the accepting edge; it is independent of the operand values.

Reset
REQ-026 When rst_n=0, the block SHALL reset immediately, without waiting for clk:
- state = IDLE;
- busy=0, done=0, diff=0, bout=0, ovf=0;
- internal shift, borrow and counter registers = 0.
REQ-027 A reset during RUN SHALL abort the operation: no done pulse is produced and no result is loaded.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted as E0.

Verification
REQ-029 Basic subtraction: a=0x05, b=0x03, bin=0, start pulsed -> busy high for 8 cycles; done at E8; diff=0x02, bout=0, ovf=0.
REQ-030 Unsigned underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
REQ-031 Signed overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
- Also check a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-032 Borrow-in: a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, ovf=0.
- Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-033 Start ignored while busy: start=1 with a=0xAA at E3 of an operation on a=0x05, b=0x03 -> result is still 0x02; no extra done.
- With start held at 1, done pulses every 10 cycles.
REQ-034 Reset mid-operation: rst_n=0 at E4 -> all outputs are 0 at once, with no done.
- After release, a=0x09, b=0x04 -> diff=0x05 at E8.

Source files
------------

// File: rtl/serial_sub8.sv
// -----------------------------------------------------------------------------
// serial_sub8
//   Bit-serial subtractor. Computes diff = a - b - bin (mod 2^WIDTH) one bit
//   per clock, LSB first. It also reports the borrow-out of the MSB stage and
//   the signed two's-complement overflow.
//
//   A start accepted in IDLE captures the operands (edge E0). After that, RUN
//   takes exactly WIDTH edges. The results are published on the last RUN edge,
//   done pulses for one cycle in DONE, and the FSM then returns to IDLE.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      capture operands and begin (only honoured in IDLE)
//   a      in   WIDTH  minuend
//   b      in   WIDTH  subtrahend
//   bin    in   1      borrow-in
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse: new result valid
//   diff   out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout   out  1      borrow-out (1 = unsigned a < b + bin)
//   ovf    out  1      signed overflow of the subtraction
//
// States
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   RUN   | one bit processed per edge, WIDTH edges total
//   DONE  | result just published, done=1 for this cycle
// -----------------------------------------------------------------------------
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // The counter must be able to reach WIDTH, because it increments on the last edge too.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // One full-subtractor slice on the current LSBs.
  logic             bit_d;
  logic             br_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  assign bit_d    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_nxt   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  assign last_bit = (cnt_q == LAST_CNT);
  assign res_next = {bit_d, res_sh_q[WIDTH-1:1]};

  // Once WIDTH bits have been shifted in, the stale LSB of res_sh_q falls off the end.
  logic res_lsb_unused;
  assign res_lsb_unused = res_sh_q[0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          br_d     = bin;
          cnt_d    = '0;
          // Keep the operand sign bits, because the shift registers lose them.
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = res_next;
        br_d     = br_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          // The bit processed on this edge is diff[MSB].
          diff_d = res_next;
          bout_d = br_nxt;
          ovf_d  = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub8.sv
// -----------------------------------------------------------------------------
// tb_serial_sub8
//   Directed bench for serial_sub8 (WIDTH=8). Inputs are driven and outputs are
//   sampled on the falling edge, so everything settles between rising edges.
// -----------------------------------------------------------------------------
module tb_serial_sub8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  // Last published result, used to confirm that outputs hold during RUN.
  logic [7:0] prev_diff = 8'h00;
  logic       prev_bout = 1'b0;
  logic       prev_ovf  = 1'b0;

  serial_sub8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Call this on a falling edge. It runs one full operation and checks busy,
  // done and output holding every cycle, then checks the result.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input string tag);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(negedge clk);
    // Scramble the inputs once the operation is accepted: only E0 may sample them.
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      check({tag, "_hold"}, {22'd0, prev_ovf, prev_bout, prev_diff}, {22'd0, ovf, bout, diff});
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    prev_diff = ed; prev_bout = eb; prev_ovf = eo;
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_keep"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    logic exp_done;
    logic exp_busy;
    logic [7:0] exp_diff;

    rst_n = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    // Reset acts without a clock edge.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "basic");
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "uflow");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "ovf_neg");
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "ovf_pos");
    run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "bin1");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "bin2");

    // Start is held high, and a is changed mid-run. The first result must be
    // 0x02. The second operation starts 10 cycles later and uses a=0xAA.
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3)  a = 8'hAA;
      if (i == 19) start = 1'b0;
      exp_done = (i == 9) || (i == 19);
      exp_busy = (i >= 1 && i <= 8) || (i >= 11 && i <= 18);
      exp_diff = (i < 9) ? prev_diff : ((i < 19) ? 8'h02 : 8'hA7);
      check("hold_done", 32'(done), 32'(exp_done));
      check("hold_busy", 32'(busy), 32'(exp_busy));
      check("hold_diff", 32'(diff), 32'(exp_diff));
    end
    prev_diff = 8'hA7; prev_bout = 1'b0; prev_ovf = 1'b0;

    // Reset arrives after E3. It aborts the operation and clears outputs at once.
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    prev_diff = 8'h00; prev_bout = 1'b0; prev_ovf = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_quiet", {30'd0, busy, done}, 32'd0);
    end

    run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
